// File: rtl/dm_responder_if.sv
// rtl/dm_responder_if.sv - CPU load/store port bundle for the data-memory responder
interface dm_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output req, we, addr, size, sign_ext, wdata,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  req, we, addr, size, sign_ext, wdata,
        output rdata, ready, err, busy
    );
endinterface

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - fixed-latency data-memory responder with byte/half/word access
module dm_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic          clk,
    input  logic          reset,
    dm_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, sx_q;
    logic [31:0]   addr_q, wdata_q;
    logic [1:0]    size_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic          req_err;
    logic [AW-1:0] idx;
    logic [31:0]   cur_word, wr_word, ld_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    // A new request is taken whenever nothing is outstanding; requests seen in WAIT are dropped.
    assign accept = bus.req && (state_q != S_WAIT);
    // The counter runs down to zero in WAIT so RESP is entered LATENCY edges after acceptance.
    assign enter_resp = (state_q == S_WAIT) && (cnt_q == '0);

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(LATENCY - 1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request checks and byte-lane merge/extract on the latched request.
    always_comb begin
        req_err  = (size_q == 2'b11) ||
                   (size_q == 2'b01 && addr_q[0]) ||
                   (size_q == 2'b10 && addr_q[1:0] != 2'b00) ||
                   ({1'b0, addr_q} >= ADDR_LIMIT);
        idx      = addr_q[AW+1:2];
        cur_word = mem_q[idx];
        wr_word  = cur_word;
        ld_byte  = cur_word[7:0];
        ld_half  = addr_q[1] ? cur_word[31:16] : cur_word[15:0];
        case (addr_q[1:0])
            2'd0: begin wr_word[7:0]   = wdata_q[7:0]; ld_byte = cur_word[7:0];   end
            2'd1: begin wr_word[15:8]  = wdata_q[7:0]; ld_byte = cur_word[15:8];  end
            2'd2: begin wr_word[23:16] = wdata_q[7:0]; ld_byte = cur_word[23:16]; end
            default: begin wr_word[31:24] = wdata_q[7:0]; ld_byte = cur_word[31:24]; end
        endcase
        if (size_q == 2'b01) begin
            wr_word = cur_word;
            if (addr_q[1]) wr_word[31:16] = wdata_q[15:0];
            else           wr_word[15:0]  = wdata_q[15:0];
        end else if (size_q == 2'b10) begin
            wr_word = wdata_q;
        end
        case (size_q)
            2'b00:   ld_word = {{24{sx_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_word = {{16{sx_q & ld_half[15]}}, ld_half};
            default: ld_word = cur_word;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request fields at acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            sx_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= 2'b00;
        end else if (accept) begin
            we_q    <= bus.we;
            sx_q    <= bus.sign_ext;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            size_q  <= bus.size;
        end
    end

    // Response data and error flag are captured on the edge entering RESP and held after.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            err_q   <= req_err;
            rdata_q <= (req_err || we_q) ? 32'h0 : ld_word;
        end
    end

    // Storage array; a store commits only on a clean response, reset clears every word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else if (enter_resp && we_q && !req_err) begin
            mem_q[idx] <= wr_word;
        end
    end

    assign bus.ready = (state_q == S_RESP);
    assign bus.err   = err_q && (state_q == S_RESP);
    assign bus.busy  = (state_q == S_WAIT);
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - directed self-checking bench for dm_responder
module tb_dm_responder;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    dm_responder_if bus ();

    dm_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [1:0] s,
                         input logic sx, input logic [31:0] d);
        bus.we       = w;
        bus.addr     = a;
        bus.size     = s;
        bus.sign_ext = sx;
        bus.wdata    = d;
    endtask

    // One request from an idle/responding DUT; returns data, error and edges to ready.
    task automatic access(input logic w, input logic [31:0] a, input logic [1:0] s,
                          input logic sx, input logic [31:0] d,
                          output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        drive(w, a, s, sx, d);
        bus.req = 1'b1;
        @(posedge clk);
        #1 bus.req = 1'b0;
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.ready) break;
        end
        rd = bus.rdata;
        e  = bus.err;
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;
    int          n;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.req = 1'b0;
        drive(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, bus.ready}, 32'h0);
        check("rst_busy",  {31'b0, bus.busy},  32'h0);
        check("rst_err",   {31'b0, bus.err},   32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // sw 0x10 with cycle-by-cycle timing
        @(negedge clk);
        drive(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
        bus.req = 1'b1;
        @(posedge clk);
        #1 bus.req = 1'b0;
        check("sw_t0_busy",  {31'b0, bus.busy},  32'h1);
        check("sw_t0_ready", {31'b0, bus.ready}, 32'h0);
        @(posedge clk); #1;
        check("sw_t1_busy",  {31'b0, bus.busy},  32'h1);
        check("sw_t1_ready", {31'b0, bus.ready}, 32'h0);
        @(posedge clk); #1;
        check("sw_t2_ready", {31'b0, bus.ready}, 32'h1);
        check("sw_t2_err",   {31'b0, bus.err},   32'h0);
        check("sw_t2_busy",  {31'b0, bus.busy},  32'h0);
        check("sw_t2_rdata", bus.rdata, 32'h0);
        @(posedge clk); #1;
        check("sw_pulse_end", {31'b0, bus.ready}, 32'h0);

        access(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, e, lat);
        check("lw10_lat", lat, 2);
        check("lw10_err", {31'b0, e}, 32'h0);
        check("lw10", rd, 32'hDEADBEEF);

        // byte lanes
        access(1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, rd, e, lat);
        access(1'b1, 32'h22, 2'b00, 1'b0, 32'h000000AA, rd, e, lat);
        check("sb22_rdata", rd, 32'h0);
        access(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, rd, e, lat);
        check("lw20", rd, 32'h11AA3344);
        access(1'b0, 32'h22, 2'b00, 1'b1, 32'h0, rd, e, lat);
        check("lb22_sx", rd, 32'hFFFFFFAA);
        access(1'b0, 32'h22, 2'b00, 1'b0, 32'h0, rd, e, lat);
        check("lbu22", rd, 32'h000000AA);
        access(1'b0, 32'h23, 2'b00, 1'b1, 32'h0, rd, e, lat);
        check("lb23_sx", rd, 32'h00000011);

        // halfwords
        access(1'b1, 32'h30, 2'b01, 1'b0, 32'h00008001, rd, e, lat);
        access(1'b0, 32'h30, 2'b01, 1'b1, 32'h0, rd, e, lat);
        check("lh30", rd, 32'hFFFF8001);
        access(1'b0, 32'h30, 2'b01, 1'b0, 32'h0, rd, e, lat);
        check("lhu30", rd, 32'h00008001);
        access(1'b0, 32'h32, 2'b01, 1'b1, 32'h0, rd, e, lat);
        check("lh32", rd, 32'h00000000);
        access(1'b1, 32'h36, 2'b01, 1'b0, 32'h0000BEEF, rd, e, lat);
        access(1'b0, 32'h34, 2'b10, 1'b0, 32'h0, rd, e, lat);
        check("sh36_upper", rd, 32'hBEEF0000);

        // rejected requests
        access(1'b1, 32'h06, 2'b10, 1'b0, 32'h12345678, rd, e, lat);
        check("sw06_lat", lat, 2);
        check("sw06_err", {31'b0, e}, 32'h1);
        access(1'b0, 32'h04, 2'b10, 1'b0, 32'h0, rd, e, lat);
        check("lw04_err", {31'b0, e}, 32'h0);
        check("lw04", rd, 32'h0);
        access(1'b0, 32'h1000, 2'b10, 1'b0, 32'h0, rd, e, lat);
        check("lw1000_err", {31'b0, e}, 32'h1);
        check("lw1000_rdata", rd, 32'h0);
        access(1'b0, 32'h10, 2'b11, 1'b0, 32'h0, rd, e, lat);
        check("size11_err", {31'b0, e}, 32'h1);
        check("size11_rdata", rd, 32'h0);
        access(1'b0, 32'h31, 2'b01, 1'b0, 32'h0, rd, e, lat);
        check("lh31_err", {31'b0, e}, 32'h1);
        @(posedge clk); #1;
        check("err_low_idle", {31'b0, bus.err}, 32'h0);

        // ignored request while busy
        @(negedge clk);
        drive(1'b1, 32'h60, 2'b10, 1'b0, 32'h00000060);
        bus.req = 1'b1;
        @(posedge clk);
        #1 drive(1'b1, 32'h64, 2'b10, 1'b0, 32'h00000064);
        @(posedge clk);
        #1 bus.req = 1'b0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.ready) n++;
            @(posedge clk); #1;
        end
        check("wait_pulse_ready_count", n, 1);
        access(1'b0, 32'h64, 2'b10, 1'b0, 32'h0, rd, e, lat);
        check("lw64_untouched", rd, 32'h0);
        access(1'b0, 32'h60, 2'b10, 1'b0, 32'h0, rd, e, lat);
        check("lw60", rd, 32'h00000060);

        // back-to-back store then load, load presented in the store's RESP cycle
        @(negedge clk);
        drive(1'b1, 32'h50, 2'b10, 1'b0, 32'hCAFEF00D);
        bus.req = 1'b1;
        @(posedge clk);
        #1 drive(1'b0, 32'h50, 2'b10, 1'b0, 32'h0);
        @(posedge clk); #1;
        check("b2b_t1_ready", {31'b0, bus.ready}, 32'h0);
        @(posedge clk); #1;
        check("b2b_first_ready", {31'b0, bus.ready}, 32'h1);
        @(posedge clk); #1;
        check("b2b_acc_busy", {31'b0, bus.busy}, 32'h1);
        check("b2b_acc_ready", {31'b0, bus.ready}, 32'h0);
        bus.req = 1'b0;
        @(posedge clk); #1;
        check("b2b_mid_ready", {31'b0, bus.ready}, 32'h0);
        @(posedge clk); #1;
        check("b2b_second_ready", {31'b0, bus.ready}, 32'h1);
        check("b2b_rdata", bus.rdata, 32'hCAFEF00D);
        @(posedge clk); #1;
        check("b2b_idle_ready", {31'b0, bus.ready}, 32'h0);
        check("b2b_rdata_held", bus.rdata, 32'hCAFEF00D);

        // reset during WAIT discards the store
        @(negedge clk);
        drive(1'b1, 32'h40, 2'b10, 1'b0, 32'h00000005);
        bus.req = 1'b1;
        @(posedge clk);
        #1 bus.req = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rstwait_ready", {31'b0, bus.ready}, 32'h0);
        check("rstwait_busy",  {31'b0, bus.busy},  32'h0);
        reset = 1'b0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (bus.ready) n++;
        end
        check("rstwait_no_ready", n, 0);
        access(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, rd, e, lat);
        check("lw40_after_rst", rd, 32'h0);
        check("lw40_lat", lat, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
